// File: rtl/dispatch_queue.sv
// ----------------------------------------------------------------------------
// dispatch_queue
//
// In-order buffer between decode and the reservation stations. Holds decoded,
// renamed instructions. It snoops the writeback bus so that buffered operands
// wake up while they wait. The head entry is dispatched whenever the
// reservation station of its exec unit is not full.
//
// Optional feature macro: DISPATCH_WB_BYPASS_EN
//   defined     : head operands combinationally forward a same-cycle writeback
//                 (a matching tag is shown as TAG_INVALID with wb_val).
//   not defined : out_* come straight from the storage registers.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               synchronous clear on branch redirect (same as rst)
//   in_valid/in_ready   decode handshake
//   in_ex_unit..in_offset  instruction fields from decode
//   wb_valid/wb_tag/wb_val writeback broadcast
//   rs_full             per-unit reservation-station full flags
//   out_valid           head entry present
//   out_ex_unit..out_offset head entry fields (zero when empty)
//   out_fire            head dispatched this cycle
//   count               occupied entries
// ----------------------------------------------------------------------------
module dispatch_queue #(
    parameter int                DEPTH       = 4,
    parameter int                DATA_W      = 32,
    parameter int                TAG_W       = 5,
    parameter int                OP_W        = 6,
    parameter int                UNIT_W      = 3,
    parameter int                UNIT_NUM    = 4,
    parameter logic [TAG_W-1:0]  TAG_INVALID = '1,
    parameter logic [UNIT_W-1:0] ERR_UNIT    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [UNIT_W-1:0]         in_ex_unit,
    input  logic [OP_W-1:0]           in_op,
    input  logic [TAG_W-1:0]          in_tag1,
    input  logic [TAG_W-1:0]          in_tag2,
    input  logic [DATA_W-1:0]         in_val1,
    input  logic [DATA_W-1:0]         in_val2,
    input  logic [TAG_W-1:0]          in_target,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [DATA_W-1:0]         in_offset,
    input  logic                      wb_valid,
    input  logic [TAG_W-1:0]          wb_tag,
    input  logic [DATA_W-1:0]         wb_val,
    input  logic [UNIT_NUM-1:0]       rs_full,
    output logic                      out_valid,
    output logic [UNIT_W-1:0]         out_ex_unit,
    output logic [OP_W-1:0]           out_op,
    output logic [TAG_W-1:0]          out_tag1,
    output logic [TAG_W-1:0]          out_tag2,
    output logic [DATA_W-1:0]         out_val1,
    output logic [DATA_W-1:0]         out_val2,
    output logic [TAG_W-1:0]          out_target,
    output logic [DATA_W-1:0]         out_pc,
    output logic [DATA_W-1:0]         out_offset,
    output logic                      out_fire,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage (data only, never reset: validity is tracked by count)
    logic [UNIT_W-1:0] unit_mem   [DEPTH];
    logic [OP_W-1:0]   op_mem     [DEPTH];
    logic [TAG_W-1:0]  tag1_mem   [DEPTH];
    logic [TAG_W-1:0]  tag2_mem   [DEPTH];
    logic [DATA_W-1:0] val1_mem   [DEPTH];
    logic [DATA_W-1:0] val2_mem   [DEPTH];
    logic [TAG_W-1:0]  target_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem     [DEPTH];
    logic [DATA_W-1:0] offset_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq;
    logic             head_blocked;

    // A broadcast of TAG_INVALID must never match: stored ready operands
    // carry that tag and would otherwise have their values overwritten.
    function automatic logic wb_match(input logic [TAG_W-1:0] tag);
        return wb_valid && (wb_tag != TAG_INVALID) && (tag == wb_tag);
    endfunction

    function automatic logic [TAG_W-1:0] wake_tag(input logic [TAG_W-1:0] tag);
        return wb_match(tag) ? TAG_INVALID : tag;
    endfunction

    function automatic logic [DATA_W-1:0] wake_val(input logic [TAG_W-1:0]  tag,
                                                   input logic [DATA_W-1:0] val);
        return wb_match(tag) ? wb_val : val;
    endfunction

    // in_ready depends on registered state only, so decode never sees a
    // combinational path from rs_full.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);

    // Undecodable instructions are consumed but never stored.
    assign enq = in_valid && in_ready && (in_ex_unit != ERR_UNIT);

    // Head field view; zero while empty.
    always_comb begin
        out_ex_unit = '0;
        out_op      = '0;
        out_tag1    = '0;
        out_tag2    = '0;
        out_val1    = '0;
        out_val2    = '0;
        out_target  = '0;
        out_pc      = '0;
        out_offset  = '0;
        if (out_valid) begin
            out_ex_unit = unit_mem[head];
            out_op      = op_mem[head];
            out_target  = target_mem[head];
            out_pc      = pc_mem[head];
            out_offset  = offset_mem[head];
`ifdef DISPATCH_WB_BYPASS_EN
            out_tag1    = wake_tag(tag1_mem[head]);
            out_tag2    = wake_tag(tag2_mem[head]);
            out_val1    = wake_val(tag1_mem[head], val1_mem[head]);
            out_val2    = wake_val(tag2_mem[head], val2_mem[head]);
`else
            out_tag1    = tag1_mem[head];
            out_tag2    = tag2_mem[head];
            out_val1    = val1_mem[head];
            out_val2    = val2_mem[head];
`endif
        end
    end

    // Units without an rs_full bit are treated as permanently full.
    always_comb begin
        head_blocked = 1'b1;
        for (int u = 0; u < UNIT_NUM; u++) begin
            if (out_ex_unit == UNIT_W'(u)) begin
                head_blocked = rs_full[u];
            end
        end
    end

    assign out_fire = out_valid && !head_blocked;

    // ---- control state: pointers and occupancy ----
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (out_fire) begin
                head <= head + 1'b1;
            end
            case ({enq, out_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- data state: enqueue write and writeback wakeup ----
    // The entry being written is woken with the same-cycle broadcast so a
    // result is never lost between decode and the queue. A wakeup landing
    // on the head as it is freed is harmless.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && (tail == PTR_W'(i))) begin
                unit_mem[i]   <= in_ex_unit;
                op_mem[i]     <= in_op;
                tag1_mem[i]   <= wake_tag(in_tag1);
                tag2_mem[i]   <= wake_tag(in_tag2);
                val1_mem[i]   <= wake_val(in_tag1, in_val1);
                val2_mem[i]   <= wake_val(in_tag2, in_val2);
                target_mem[i] <= in_target;
                pc_mem[i]     <= in_pc;
                offset_mem[i] <= in_offset;
            end else begin
                tag1_mem[i]   <= wake_tag(tag1_mem[i]);
                tag2_mem[i]   <= wake_tag(tag2_mem[i]);
                val1_mem[i]   <= wake_val(tag1_mem[i], val1_mem[i]);
                val2_mem[i]   <= wake_val(tag2_mem[i], val2_mem[i]);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// ----------------------------------------------------------------------------
// tb_dispatch_queue
//
// Self-checking bench for dispatch_queue. A table of single-cycle vectors
// (inputs held across one rising edge, outputs compared 1ns later) covers
// fill/stall, wakeup, ordered dispatch, error units and out-of-range units.
// Hand-written sequences cover reset, flush priority, pointer wrap and the
// head-operand writeback bypass.
// ----------------------------------------------------------------------------
module tb_dispatch_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int OP_W   = 6;
    localparam int UNIT_W = 3;
    localparam int UNIT_NUM = 4;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready;
    logic [UNIT_W-1:0] in_ex_unit;
    logic [OP_W-1:0]   in_op;
    logic [TAG_W-1:0]  in_tag1, in_tag2, in_target;
    logic [DATA_W-1:0] in_val1, in_val2, in_pc, in_offset;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_val;
    logic [UNIT_NUM-1:0] rs_full;
    logic              out_valid, out_fire;
    logic [UNIT_W-1:0] out_ex_unit;
    logic [OP_W-1:0]   out_op;
    logic [TAG_W-1:0]  out_tag1, out_tag2, out_target;
    logic [DATA_W-1:0] out_val1, out_val2, out_pc, out_offset;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dispatch_queue #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
        .UNIT_W(UNIT_W), .UNIT_NUM(UNIT_NUM)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ex_unit(in_ex_unit), .in_op(in_op),
        .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_val1(in_val1), .in_val2(in_val2),
        .in_target(in_target), .in_pc(in_pc), .in_offset(in_offset),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
        .rs_full(rs_full),
        .out_valid(out_valid), .out_ex_unit(out_ex_unit), .out_op(out_op),
        .out_tag1(out_tag1), .out_tag2(out_tag2),
        .out_val1(out_val1), .out_val2(out_val2),
        .out_target(out_target), .out_pc(out_pc), .out_offset(out_offset),
        .out_fire(out_fire), .count(count)
    );

    typedef struct {
        logic        vi;
        logic [2:0]  unit;
        logic [4:0]  t1;
        logic [31:0] v1;
        logic [4:0]  t2;
        logic [31:0] v2;
        logic [4:0]  tgt;
        logic        wv;
        logic [4:0]  wt;
        logic [31:0] wd;
        logic [3:0]  rsf;
        logic        fl;
        logic [2:0]  e_cnt;
        logic        e_ovld;
        logic        e_ofire;
        logic        e_irdy;
        logic [4:0]  e_tgt;
        logic [4:0]  e_t1;
        logic [31:0] e_v1;
        logic [4:0]  e_t2;
        logic [31:0] e_v2;
    } vec_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vi, input logic [2:0] unit, input logic [4:0] t1,
                         input logic [31:0] v1, input logic [4:0] t2, input logic [31:0] v2,
                         input logic [4:0] tgt, input logic wv, input logic [4:0] wt,
                         input logic [31:0] wd, input logic [3:0] rsf, input logic fl);
        in_valid   = vi;
        in_ex_unit = unit;
        in_op      = 6'h2;
        in_tag1    = t1;
        in_val1    = v1;
        in_tag2    = t2;
        in_val2    = v2;
        in_target  = tgt;
        in_pc      = 32'h1000 + 32'(tgt);
        in_offset  = 32'h4;
        wb_valid   = wv;
        wb_tag     = wt;
        wb_val     = wd;
        rs_full    = rsf;
        flush      = fl;
    endtask

    task automatic idle(input logic [3:0] rsf);
        drive(1'b0, 3'd1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, rsf, 1'b0);
    endtask

    task automatic enq(input logic [4:0] tgt, input logic [4:0] t1, input logic [31:0] v1,
                       input logic [3:0] rsf);
        drive(1'b1, 3'd1, t1, v1, 5'h1F, 32'h0, tgt, 1'b0, 5'd0, 32'h0, rsf, 1'b0);
    endtask

    initial begin
        logic [4:0] model [$];

        //              vi unit t1     v1        t2     v2     tgt  wv wt     wd           rsf  fl | cnt ov of ir tgt  t1     v1            t2     v2
        tbl[0]  = '{1, 3'd1, 5'd7,  32'h11, 5'd3,  32'h12, 5'd1, 0, 5'd0,  32'h0,    4'hF, 0, 3'd1, 1, 0, 1, 5'd1, 5'd7,  32'h11,   5'd3,  32'h12};
        tbl[1]  = '{1, 3'd1, 5'h1F, 32'h22, 5'd9,  32'h0,  5'd2, 1, 5'd9,  32'h5,    4'hF, 0, 3'd2, 1, 0, 1, 5'd1, 5'd7,  32'h11,   5'd3,  32'h12};
        tbl[2]  = '{1, 3'd1, 5'd4,  32'h33, 5'h1F, 32'h34, 5'd3, 1, 5'd7,  32'hDEAD, 4'hF, 0, 3'd3, 1, 0, 1, 5'd1, 5'h1F, 32'hDEAD, 5'd3,  32'h12};
        tbl[3]  = '{1, 3'd1, 5'h1F, 32'h44, 5'h1F, 32'h45, 5'd4, 0, 5'd0,  32'h0,    4'hF, 0, 3'd4, 1, 0, 0, 5'd1, 5'h1F, 32'hDEAD, 5'd3,  32'h12};
        tbl[4]  = '{1, 3'd1, 5'h1F, 32'h50, 5'h1F, 32'h51, 5'd5, 0, 5'd0,  32'h0,    4'hF, 0, 3'd4, 1, 0, 0, 5'd1, 5'h1F, 32'hDEAD, 5'd3,  32'h12};
        tbl[5]  = '{0, 3'd1, 5'd0,  32'h0,  5'd0,  32'h0,  5'd0, 0, 5'd0,  32'h0,    4'h0, 0, 3'd3, 1, 1, 1, 5'd2, 5'h1F, 32'h22,   5'h1F, 32'h5};
        tbl[6]  = '{0, 3'd1, 5'd0,  32'h0,  5'd0,  32'h0,  5'd0, 1, 5'd4,  32'h99,   4'h0, 0, 3'd2, 1, 1, 1, 5'd3, 5'h1F, 32'h99,   5'h1F, 32'h34};
        tbl[7]  = '{0, 3'd1, 5'd0,  32'h0,  5'd0,  32'h0,  5'd0, 0, 5'd0,  32'h0,    4'h0, 0, 3'd1, 1, 1, 1, 5'd4, 5'h1F, 32'h44,   5'h1F, 32'h45};
        tbl[8]  = '{0, 3'd1, 5'd0,  32'h0,  5'd0,  32'h0,  5'd0, 0, 5'd0,  32'h0,    4'h0, 0, 3'd0, 0, 0, 1, 5'd0, 5'd0,  32'h0,    5'd0,  32'h0};
        tbl[9]  = '{1, 3'd0, 5'h1F, 32'h70, 5'h1F, 32'h71, 5'd7, 0, 5'd0,  32'h0,    4'h0, 0, 3'd0, 0, 0, 1, 5'd0, 5'd0,  32'h0,    5'd0,  32'h0};
        tbl[10] = '{1, 3'd5, 5'h1F, 32'h60, 5'h1F, 32'h61, 5'd6, 0, 5'd0,  32'h0,    4'h0, 0, 3'd1, 1, 0, 1, 5'd6, 5'h1F, 32'h60,   5'h1F, 32'h61};
        tbl[11] = '{0, 3'd1, 5'd0,  32'h0,  5'd0,  32'h0,  5'd0, 1, 5'h1F, 32'hCC,   4'h0, 0, 3'd1, 1, 0, 1, 5'd6, 5'h1F, 32'h60,   5'h1F, 32'h61};
        tbl[12] = '{0, 3'd1, 5'd0,  32'h0,  5'd0,  32'h0,  5'd0, 0, 5'd0,  32'h0,    4'h0, 1, 3'd0, 0, 0, 1, 5'd0, 5'd0,  32'h0,    5'd0,  32'h0};

        // Reset held for two cycles
        idle(4'hF);
        rst = 1'b1;
        tick();
        tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset count", 32'(count), 32'd0);
        chk("reset out_val1", out_val1, 32'd0);
        chk("reset out_fire", 32'(out_fire), 32'd0);
        rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].vi, tbl[i].unit, tbl[i].t1, tbl[i].v1, tbl[i].t2, tbl[i].v2,
                  tbl[i].tgt, tbl[i].wv, tbl[i].wt, tbl[i].wd, tbl[i].rsf, tbl[i].fl);
            tick();
            chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ovld));
            chk($sformatf("row%0d out_fire", i), 32'(out_fire), 32'(tbl[i].e_ofire));
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
            chk($sformatf("row%0d out_target", i), 32'(out_target), 32'(tbl[i].e_tgt));
            chk($sformatf("row%0d out_tag1", i), 32'(out_tag1), 32'(tbl[i].e_t1));
            chk($sformatf("row%0d out_val1", i), out_val1, tbl[i].e_v1);
            chk($sformatf("row%0d out_tag2", i), 32'(out_tag2), 32'(tbl[i].e_t2));
            chk($sformatf("row%0d out_val2", i), out_val2, tbl[i].e_v2);
        end

        // Flush wins over same-cycle enqueue, dispatch and wakeup
        idle(4'hF);
        for (int k = 0; k < 3; k++) begin
            enq(5'(10 + k), 5'd3, 32'h0, 4'hF);
            tick();
        end
        chk("flush pre count", 32'(count), 32'd3);
        drive(1'b1, 3'd1, 5'd3, 32'h0, 5'd3, 32'h0, 5'd13, 1'b1, 5'd3, 32'h77, 4'h0, 1'b1);
        #1;
        chk("flush pre out_fire", 32'(out_fire), 32'd1);
        tick();
        chk("flush count", 32'(count), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        chk("flush out_target", 32'(out_target), 32'd0);
        idle(4'h0);
        tick();
        chk("flush after count", 32'(count), 32'd0);

        // Wrap: ten enqueue/dispatch pairs at count 2
        model.delete();
        for (int k = 0; k < 2; k++) begin
            enq(5'(20 + k), 5'h1F, 32'h0, 4'hF);
            model.push_back(5'(20 + k));
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            enq(5'(22 + k), 5'h1F, 32'h0, 4'h0);
            #1;
            chk($sformatf("wrap%0d head", k), 32'(out_target), 32'(model[0]));
            tick();
            void'(model.pop_front());
            model.push_back(5'(22 + k));
            chk($sformatf("wrap%0d count", k), 32'(count), 32'd2);
        end
        idle(4'h0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("drain%0d head", k), 32'(out_target), 32'(model[0]));
            tick();
            void'(model.pop_front());
        end
        chk("drain count", 32'(count), 32'd0);

        // Head operand with a writeback in its dispatch cycle
        enq(5'd30, 5'd2, 32'h10, 4'hF);
        tick();
        drive(1'b0, 3'd1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd2, 32'h77, 4'h0, 1'b0);
        #1;
`ifdef DISPATCH_WB_BYPASS_EN
        chk("bypass out_tag1", 32'(out_tag1), 32'h1F);
        chk("bypass out_val1", out_val1, 32'h77);
`else
        chk("nobypass out_tag1", 32'(out_tag1), 32'd2);
        chk("nobypass out_val1", out_val1, 32'h10);
`endif
        chk("bypass out_fire", 32'(out_fire), 32'd1);
        tick();
        chk("bypass count", 32'(count), 32'd0);
        idle(4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
